stopwatch_display_scan: RTL and testbench
=========================================

Name: stopwatch_display_scan

Overview:
- Downstream consumer of the stopwatch counter.
- Takes the binary minute, second and centisecond values and drives a 6-digit multiplexed 7-segment display showing MM.SS.CC.
- Captures a tear-free snapshot once per scan frame, converts each field to two BCD digits, and scans one digit per scan tick.
- Outputs are active-low, registered anode and segment lines going straight to board pins.

Parameters:
- SCAN_DIV, 4: clock cycles per digit slot, legal range ≥1. A tick occurs when the prescaler equals SCAN_DIV-1.
- BLANK_LZ, 1: when 1, minute tens digit is blanked if it is 0.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- min_i  input  6  minutes, binary.
- sec_i  input  6  seconds, binary.
- ms_10_i  input  7  centiseconds, binary.
- blank_i  input  1  1 = all digits off; scanning continues.
- an_o  output  6  digit enables, active-low. an_o[5] = minute tens (leftmost), an_o[0] = centisecond units.
- seg_o  output  7  segments gfedcba, active-low; seg_o[6]=g, seg_o[0]=a.
- dp_o  output  1  decimal point, active-low.

Behaviour:
- Reset (synchronous, active-high, as decided), at the edge where rst=1:
  - prescaler=0, idx=0, snapshot fields=0.
  - an_o=6'b111111, seg_o=7'h7F, dp_o=1.
  - rst wins over every other event in the same cycle.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. Tick is asserted on the cycle where the prescaler equals SCAN_DIV-1. With SCAN_DIV=1, tick fires every cycle.
- Digit index:
  - On a tick edge, idx advances 0→1→…→5→0.
  - Frame = 6 slots = 6*SCAN_DIV cycles.
- Snapshot:
  - On the tick edge where idx wraps 5→0, min_i, sec_i and ms_10_i are all captured together.
  - Inputs are not sampled at any other time, so one frame never mixes two input values.
- Digit mapping:
  - idx k drives an_o[k].
  - k=0,1: centisecond units, tens.
  - k=2,3: second units, tens.
  - k=4,5: minute units, tens.
- BCD: each field value v ≤ 99 splits into tens = v/10 and units = v mod 10. Minutes and seconds 60–63 are displayed literally (e.g. 61 → "61").
- Out of range: a centisecond value of 100–127 shows a dash (seg 7'h3F) on both k=0 and k=1.
- Segment codes, digits 0–9: 40,79,24,30,19,12,02,78,00,10 (hex). Blank = 7F.
- Output register:
  - On every edge (tick or not), an_o, seg_o and dp_o are loaded from the current idx and snapshot.
  - This gives 1-cycle latency from an idx change to the pins.
  - Exactly one an_o bit is low when not blanked.
- Decimal point: dp_o=0 when k=4 or k=2 (after minute units and after second units); 1 otherwise.
- Leading-zero blanking: with BLANK_LZ=1 and snapshot minutes <10, at k=5 seg_o=7F and dp_o=1. an_o[5] is still driven low.
- blank_i=1: at the next edge an_o=111111, seg_o=7F, dp_o=1. idx, prescaler and snapshot keep running. Deassertion resumes at the current idx on the next edge.
- Reset mid-frame: everything returns to the reset state, and the snapshot reads 0 until the next 5→0 wrap. After release the display shows 00.00.00 (or " 0.00.00" with BLANK_LZ).

Decomposition:
- Shared package (stopwatch_pkg):
  - Field width constants MIN_W=6, SEC_W=6, CS_W=7, NUM_DIGITS=6.
  - Segment-code constants SEG_BLANK and SEG_DASH.
  - The 0–9 segment lookup function.
- One sub-module, bin2bcd_99: combinational 7-bit binary → {tens[3:0], units[3:0], ovf}, with ovf=1 for values >99. It is instantiated once, on the digit-selected field.
- Top level holds the prescaler, idx, snapshot and output registers.

Test Plan:
- Reset: hold rst=1 for 3 cycles with arbitrary inputs → an_o=3F, seg_o=7F, dp_o=1 every cycle. After release, the first output has an_o=111110 and seg_o=40.
- Full frame, SCAN_DIV=4, inputs 12:34.56 applied before a 5→0 wrap → next frame, each slot held 4 cycles:
  - an_o: 111110 seg 02, 111101 seg 12, 111011 seg 19, 110111 seg 30, 101111 seg 24 dp 0, 011111 seg 79.
  - dp_o=0 only in the slot with an_o=101111 (k=4) and the slot with an_o=111011 (k=2).
- Snapshot coherency: change inputs from 12:34.56 to 59:59.99 at mid-frame slot k=3 → the remainder of the frame still shows 12:34.56 digits, and the next frame shows 59:59.99.
- Leading zero and overflow: min=5, sec=0, cs=120, BLANK_LZ=1 → k=5 seg 7F, k=4 seg 12, k=3,2 seg 40, k=1,0 seg 3F.
- blank_i: assert for 10 cycles mid-frame → an_o=3F throughout. On release the digit shown matches the idx reached after (10 cycles / SCAN_DIV) ticks, with no slot skipped or repeated.
- SCAN_DIV=1 with rst asserted at k=3 → the next cycle shows the reset state. A frame restarts at k=0 one cycle after release, and an_o rotates every cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared widths, segment codes and the digit-to-segment lookup for the stopwatch display.
package stopwatch_pkg;

  localparam int unsigned MIN_W      = 6;
  localparam int unsigned SEC_W      = 6;
  localparam int unsigned CS_W       = 7;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned SEG_W      = 7;

  // Active-low gfedcba codes.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

  function automatic logic [SEG_W-1:0] seg_lut(input logic [3:0] digit);
    logic [SEG_W-1:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_99.sv
// Combinational 7-bit binary to two BCD digits; ovf flags values above 99.
module bin2bcd_99
  import stopwatch_pkg::*;
(
  input  logic [CS_W-1:0] bin_i,
  output logic [3:0]      tens_o,
  output logic [3:0]      units_o,
  output logic            ovf_o
);

  logic [CS_W-1:0] tens_full;
  logic [CS_W-1:0] units_full;

  always_comb begin
    tens_full  = CS_W'(bin_i / CS_W'(10));
    units_full = CS_W'(bin_i % CS_W'(10));
    tens_o     = 4'(tens_full);
    units_o    = 4'(units_full);
    ovf_o      = (bin_i > CS_W'(99));
  end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Six-digit multiplexed 7-segment scanner for MM.SS.CC with a per-frame input snapshot.
module stopwatch_display_scan
  import stopwatch_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MIN_W-1:0]      min_i,
  input  logic [SEC_W-1:0]      sec_i,
  input  logic [CS_W-1:0]       ms_10_i,
  input  logic                  blank_i,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [SEG_W-1:0]      seg_o,
  output logic                  dp_o
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [MIN_W-1:0]      min_q, min_d;
  logic [SEC_W-1:0]      sec_q, sec_d;
  logic [CS_W-1:0]       cs_q, cs_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  tick_c;
  logic [CS_W-1:0]       field_c;
  logic [3:0]            tens_c, units_c, digit_c;
  logic                  ovf_c;

  bin2bcd_99 u_bcd (
    .bin_i   (field_c),
    .tens_o  (tens_c),
    .units_o (units_c),
    .ovf_o   (ovf_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
      min_q <= '0;
      sec_q <= '0;
      cs_q  <= '0;
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      min_q <= min_d;
      sec_q <= sec_d;
      cs_q  <= cs_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  always_comb begin
    tick_c  = (pre_q == PRE_W'(SCAN_DIV - 1));
    pre_d   = tick_c ? '0 : pre_q + PRE_W'(1);
    idx_d   = idx_q;
    min_d   = min_q;
    sec_d   = sec_q;
    cs_d    = cs_q;
    field_c = cs_q;
    an_d    = '1;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;

    if (tick_c) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      // Capture all fields together at the frame boundary so a frame never tears.
      if (idx_q == IDX_LAST) begin
        min_d = min_i;
        sec_d = sec_i;
        cs_d  = ms_10_i;
      end
    end

    case (idx_q)
      3'd2, 3'd3: field_c = CS_W'(sec_q);
      3'd4, 3'd5: field_c = CS_W'(min_q);
      default:    field_c = cs_q;
    endcase

    digit_c = idx_q[0] ? tens_c : units_c;
    an_d    = ~(NUM_DIGITS'(1) << idx_q);
    seg_d   = ovf_c ? SEG_DASH : seg_lut(digit_c);
    dp_d    = !((idx_q == 3'd2) || (idx_q == 3'd4));

    if (BLANK_LZ && (idx_q == IDX_LAST) && (min_q < MIN_W'(10))) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end

    if (blank_i) begin
      an_d  = '1;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Scoreboard bench: two scanner instances (SCAN_DIV=4 with leading-zero blanking, SCAN_DIV=1 without).
module tb_stopwatch_display_scan;

  logic       clk;
  logic       rst;
  logic [5:0] min_v;
  logic [5:0] sec_v;
  logic [6:0] cs_v;
  logic       blank;

  logic [5:0] an4, an1;
  logic [6:0] seg4, seg1;
  logic       dp4, dp1;

  int passed = 0;
  int total  = 0;
  int cycle  = 0;

  logic [13:0] q4[$];
  logic [13:0] q1[$];

  int div_p[2];
  bit lz_p[2];
  int edges[2];
  int snap_min[2];
  int snap_sec[2];
  int snap_cs[2];

  stopwatch_display_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .min_i(min_v), .sec_i(sec_v), .ms_10_i(cs_v),
    .blank_i(blank), .an_o(an4), .seg_o(seg4), .dp_o(dp4)
  );

  stopwatch_display_scan #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .min_i(min_v), .sec_i(sec_v), .ms_10_i(cs_v),
    .blank_i(blank), .an_o(an1), .seg_o(seg1), .dp_o(dp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // What a human would see on digit k of "MM.SS.CC" given the frozen frame values.
  function automatic logic [13:0] show(input int k, input int mn, input int sc, input int cs,
                                       input bit lz, input bit blk);
    int v;
    logic [5:0] an;
    logic [6:0] seg;
    logic dp;
    if (blk) return {6'h3F, 7'h7F, 1'b1};
    an = 6'h3F;
    an[k] = 1'b0;
    v = (k < 2) ? cs : (k < 4) ? sc : mn;
    if (k < 2 && cs > 99) seg = 7'h3F;
    else seg = digit_seg((k % 2 == 1) ? v / 10 : v % 10);
    dp = (k == 2 || k == 4) ? 1'b0 : 1'b1;
    if (lz && k == 5 && mn < 10) begin
      seg = 7'h7F;
      dp  = 1'b1;
    end
    return {an, seg, dp};
  endfunction

  initial begin
    div_p[0] = 4; lz_p[0] = 1'b1;
    div_p[1] = 1; lz_p[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      edges[i] = 0; snap_min[i] = 0; snap_sec[i] = 0; snap_cs[i] = 0;
    end
  end

  // Reference model: time since reset decides the slot; frame boundaries freeze the inputs.
  always @(posedge clk) begin
    logic [13:0] e;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        e = {6'h3F, 7'h7F, 1'b1};
        edges[i] = 0;
        snap_min[i] = 0; snap_sec[i] = 0; snap_cs[i] = 0;
      end else begin
        e = show((edges[i] / div_p[i]) % 6, snap_min[i], snap_sec[i], snap_cs[i],
                 lz_p[i], blank);
        if (edges[i] % (6 * div_p[i]) == 6 * div_p[i] - 1) begin
          snap_min[i] = int'(min_v);
          snap_sec[i] = int'(sec_v);
          snap_cs[i]  = int'(cs_v);
        end
        edges[i]++;
      end
      if (i == 0) q4.push_back(e);
      else        q1.push_back(e);
    end
  end

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                  name, cycle, act[13:8], act[7:1], act[0], exp[13:8], exp[7:1], exp[0]);
  endtask

  // Monitor: sample away from the active edge and retire one expectation per DUT per cycle.
  always @(negedge clk) begin
    logic [13:0] exp;
    cycle++;
    if (q4.size() > 0) begin
      exp = q4.pop_front();
      check("div4_lz", {an4, seg4, dp4}, exp);
    end
    if (q1.size() > 0) begin
      exp = q1.pop_front();
      check("div1", {an1, seg1, dp1}, exp);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input int mn, input int sc, input int cs);
    min_v = 6'(mn);
    sec_v = 6'(sc);
    cs_v  = 7'(cs);
  endtask

  initial begin
    rst = 1'b1;
    blank = 1'b0;
    set_in($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 127));
    cyc(3);
    rst = 1'b0;

    set_in(12, 34, 56);
    cyc(48);
    cyc(13);
    set_in(59, 59, 99);
    cyc(48);

    set_in(5, 0, 120);
    cyc(48);

    cyc(6);
    blank = 1'b1;
    cyc(10);
    blank = 1'b0;
    cyc(30);

    for (int n = 0; n < 2000; n++) begin
      rst   = ($urandom_range(0, 63) == 0);
      blank = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0)
        set_in($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 127));
      cyc(1);
    end
    rst = 1'b0;
    blank = 1'b0;
    cyc(30);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
